sram_host_sequencer: RTL and testbench
======================================

Name: sram_host_sequencer

Overview:
Host-side master that drives the 16-bit/256K-word SRAM pass-through wrapper's host port (address, data, WE_N/OE_N/CE_N, byte enables).
- Accepts single or burst read/write commands over a ready/valid handshake.
- Generates SETUP / ACCESS / HOLD strobe timing with programmable wait states.
- Returns read data with a valid pulse.
- Sits between frame-buffer clients (capture writer, VGA reader) and the SRAM wrapper.

Parameters:
ACCESS_CYC, 2, cycles WE_N/OE_N data phase lasts per word (legal range 1..15)
ADDR_W, 18, word address width
DATA_W, 16, data width

Ports:
iCLK  in  1  system clock
iRST_N  in  1  asynchronous active-low reset
iREQ  in  1  command valid
iWR  in  1  1=write, 0=read; sampled with iREQ
iADDR  in  ADDR_W  start word address
iLEN  in  8  burst length minus one (0 = single word)
iBE_N  in  2  active-low byte enables, held for whole burst
iWDATA  in  DATA_W  write data
oREADY  out  1  command accepted when iREQ&oREADY at rising edge
oWNEXT  out  1  requests next write word
oRDATA  out  DATA_W  captured read data
oRVALID  out  1  one-cycle pulse, oRDATA valid
oDONE  out  1  one-cycle pulse at final HOLD of a command
oSRAM_ADDR  out  ADDR_W  to wrapper iADDR
oSRAM_DATA  out  DATA_W  to wrapper iDATA
oSRAM_WE_N  out  1  to wrapper iWE_N
oSRAM_OE_N  out  1  to wrapper iOE_N
oSRAM_CE_N  out  1  to wrapper iCE_N
oSRAM_BE_N  out  2  to wrapper iBE_N
iSRAM_DATA  in  DATA_W  from wrapper oDATA

Behaviour:
- One clock iCLK; iRST_N asynchronous assert, synchronous deassert by the upstream reset bridge.
- Reset values:
  - State IDLE; oREADY=1 (combinational: state==IDLE).
  - oWNEXT=0, oRVALID=0, oDONE=0, oRDATA=0.
  - oSRAM_CE_N=1, oSRAM_WE_N=1, oSRAM_OE_N=1, oSRAM_BE_N=2'b11, oSRAM_ADDR=0, oSRAM_DATA=0.
- Strobes and address are registered outputs, with no combinational path from iREQ to the SRAM side.
- States: IDLE, SETUP, ACCESS, HOLD.
- IDLE:
  - On iREQ=1, latch iWR, iADDR, iLEN into word counter cnt, iBE_N, and iWDATA (word 0).
  - Go to SETUP.
- SETUP (1 cycle):
  - CE_N=0, address valid, BE_N driven, WE_N=1.
  - OE_N=0 for reads, 1 for writes.
  - Next: ACCESS with wait counter=ACCESS_CYC-1.
- ACCESS (ACCESS_CYC cycles):
  - Writes: WE_N=0, oSRAM_DATA stable.
  - Reads: OE_N=0; on the edge leaving the last ACCESS cycle, oRDATA<=iSRAM_DATA.
- HOLD (1 cycle):
  - WE_N=1, CE_N=0, address and data unchanged (hold time).
  - Reads: oRVALID=1.
  - Writes with cnt!=0: oWNEXT=1; iWDATA is latched at the HOLD->SETUP edge.
  - If cnt!=0: cnt-=1, address+=1, go to SETUP.
  - Else: oDONE=1, go to IDLE.
  - On the HOLD->IDLE edge, CE_N/OE_N/BE_N return to 1/1/11.
- Read latency: oRVALID asserts ACCESS_CYC+2 cycles after the accepting edge. Burst throughput is 1 word per ACCESS_CYC+2 cycles.
- Address wrap: 18'h3FFFF+1 = 18'h00000, with no error.
- iREQ during SETUP/ACCESS/HOLD is ignored (oREADY=0). Minimum one IDLE cycle between commands.
- iWR/iADDR/iLEN/iBE_N changes after acceptance have no effect.
- Reset mid-operation: strobes deassert immediately (async), the command is abandoned, and no oRVALID/oDONE is produced.
- WE_N and OE_N are never simultaneously 0. WE_N is never 0 while CE_N=1.

Test Plan:
- Reset, then idle 5 cycles -> oREADY=1; CE_N/WE_N/OE_N=1; BE_N=11; all pulses 0.
- Single write, ACCESS_CYC=2, addr 18'h00010, data 16'hA5C3, BE_N=00 -> CE_N low 4 cycles; WE_N low exactly cycles 2-3 after accept; oDONE at cycle 4; model memory[0x10]=A5C3.
- Single read of 0x10 after the write -> oRVALID pulse 4 cycles after accept with oRDATA=A5C3; OE_N low cycles 1-3; WE_N stays 1.
- Write burst iLEN=3 at 18'h3FFFE with data 1,2,3,4 supplied on oWNEXT -> writes to 3FFFE, 3FFFF, 00000, 00001; three oWNEXT pulses; one oDONE.
- Read burst iLEN=3 from 3FFFE -> four oRVALID pulses spaced 4 cycles apart returning 1,2,3,4; iREQ held high throughout is not re-accepted until the IDLE cycle after oDONE.
- Assert iRST_N=0 during the ACCESS of a write -> WE_N/CE_N go to 1 within the same cycle (async); no oDONE; next command after reset runs normally.

Source files
------------

// File: rtl/sram_host_sequencer_if.sv
// Command and SRAM-side signals of the host sequencer.
// master: the frame-buffer client plus SRAM wrapper that surround the sequencer.
// slave:  the sequencer itself.
interface sram_host_sequencer_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              iREQ;
    logic              iWR;
    logic [ADDR_W-1:0] iADDR;
    logic [7:0]        iLEN;
    logic [1:0]        iBE_N;
    logic [DATA_W-1:0] iWDATA;
    logic              oREADY;
    logic              oWNEXT;
    logic [DATA_W-1:0] oRDATA;
    logic              oRVALID;
    logic              oDONE;
    logic [ADDR_W-1:0] oSRAM_ADDR;
    logic [DATA_W-1:0] oSRAM_DATA;
    logic              oSRAM_WE_N;
    logic              oSRAM_OE_N;
    logic              oSRAM_CE_N;
    logic [1:0]        oSRAM_BE_N;
    logic [DATA_W-1:0] iSRAM_DATA;

    modport master (
        output iREQ, iWR, iADDR, iLEN, iBE_N, iWDATA, iSRAM_DATA,
        input  oREADY, oWNEXT, oRDATA, oRVALID, oDONE,
        input  oSRAM_ADDR, oSRAM_DATA, oSRAM_WE_N, oSRAM_OE_N, oSRAM_CE_N, oSRAM_BE_N
    );

    modport slave (
        input  iREQ, iWR, iADDR, iLEN, iBE_N, iWDATA, iSRAM_DATA,
        output oREADY, oWNEXT, oRDATA, oRVALID, oDONE,
        output oSRAM_ADDR, oSRAM_DATA, oSRAM_WE_N, oSRAM_OE_N, oSRAM_CE_N, oSRAM_BE_N
    );
endinterface

// File: rtl/sram_host_sequencer.sv
// Host-side SRAM sequencer: single/burst read and write commands with
// SETUP / ACCESS / HOLD strobe timing. All SRAM-side outputs are registered.
//
// state  | meaning
// IDLE   | waiting for a command, oREADY high, strobes inactive
// SETUP  | CE_N low, address/BE_N valid, OE_N low for reads
// ACCESS | ACCESS_CYC cycles of WE_N (write) or OE_N (read) low
// HOLD   | strobes released except CE_N, pulses issued, next word or finish
module sram_host_sequencer #(
    parameter int ACCESS_CYC = 2,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    sram_host_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} seqStateT;

    seqStateT   state;
    seqStateT   nextState;
    logic       isWr;
    logic [7:0] cnt;
    logic [3:0] waitCnt;

    assign bus.oREADY = (state == IDLE);

    // State register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.iREQ) nextState = SETUP;
            SETUP:   nextState = ACCESS;
            ACCESS:  if (waitCnt == 4'd0) nextState = HOLD;
            HOLD:    nextState = (cnt != 8'd0) ? SETUP : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Command latches, word/wait counters and registered SRAM strobes.
    // Strobes are set on the edge entering each phase, so they line up with the state.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            isWr           <= 1'b0;
            cnt            <= 8'd0;
            waitCnt        <= 4'd0;
            bus.oWNEXT     <= 1'b0;
            bus.oRVALID    <= 1'b0;
            bus.oDONE      <= 1'b0;
            bus.oRDATA     <= '0;
            bus.oSRAM_ADDR <= '0;
            bus.oSRAM_DATA <= '0;
            bus.oSRAM_CE_N <= 1'b1;
            bus.oSRAM_WE_N <= 1'b1;
            bus.oSRAM_OE_N <= 1'b1;
            bus.oSRAM_BE_N <= 2'b11;
        end else begin
            bus.oWNEXT  <= 1'b0;
            bus.oRVALID <= 1'b0;
            bus.oDONE   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iREQ) begin
                        isWr           <= bus.iWR;
                        cnt            <= bus.iLEN;
                        bus.oSRAM_ADDR <= bus.iADDR;
                        bus.oSRAM_DATA <= bus.iWDATA;
                        bus.oSRAM_BE_N <= bus.iBE_N;
                        bus.oSRAM_CE_N <= 1'b0;
                        bus.oSRAM_OE_N <= bus.iWR;
                    end
                end
                SETUP: begin
                    waitCnt        <= 4'(ACCESS_CYC - 1);
                    bus.oSRAM_WE_N <= !isWr;
                end
                ACCESS: begin
                    if (waitCnt == 4'd0) begin
                        bus.oSRAM_WE_N <= 1'b1;
                        bus.oSRAM_OE_N <= 1'b1;
                        if (!isWr) begin
                            bus.oRDATA <= bus.iSRAM_DATA;
                        end
                        bus.oRVALID <= !isWr;
                        bus.oWNEXT  <= isWr && (cnt != 8'd0);
                        bus.oDONE   <= (cnt == 8'd0);
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt != 8'd0) begin
                        cnt            <= cnt - 8'd1;
                        bus.oSRAM_ADDR <= bus.oSRAM_ADDR + 1'b1;
                        bus.oSRAM_OE_N <= isWr;
                        if (isWr) begin
                            bus.oSRAM_DATA <= bus.iWDATA;
                        end
                    end else begin
                        bus.oSRAM_CE_N <= 1'b1;
                        bus.oSRAM_OE_N <= 1'b1;
                        bus.oSRAM_BE_N <= 2'b11;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_host_sequencer.sv
// Self-checking bench for sram_host_sequencer: timeline model of the strobes
// per cycle, a reference memory for data, and a simple SRAM array on the bus.
module tb_sram_host_sequencer;
    localparam int AC    = 2;
    localparam int AW    = 18;
    localparam int DW    = 16;
    localparam int P     = AC + 2;
    localparam int AMASK = (1 << AW) - 1;

    logic iCLK = 1'b0;
    logic iRST_N = 1'b0;
    always #5 iCLK = ~iCLK;

    sram_host_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_host_sequencer #(.ACCESS_CYC(AC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus)
    );

    int passCnt = 0;
    int totalCnt = 0;

    // SRAM array driven by the DUT strobes.
    bit [15:0] sramMem [0:AMASK];
    always @(posedge iCLK) begin
        if (iRST_N && !bus.oSRAM_CE_N && !bus.oSRAM_WE_N) begin
            if (!bus.oSRAM_BE_N[0]) sramMem[bus.oSRAM_ADDR][7:0]  <= bus.oSRAM_DATA[7:0];
            if (!bus.oSRAM_BE_N[1]) sramMem[bus.oSRAM_ADDR][15:8] <= bus.oSRAM_DATA[15:8];
        end
    end
    assign bus.iSRAM_DATA = (!bus.oSRAM_CE_N && !bus.oSRAM_OE_N) ? sramMem[bus.oSRAM_ADDR] : 16'hDEAD;

    // Reference memory.
    logic [15:0] modelMem [int];
    logic [15:0] wq [$];

    function automatic logic [15:0] modelRd(int a);
        return modelMem.exists(a) ? modelMem[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] mergeBe(logic [15:0] old, logic [15:0] nw, logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (!be[0]) r[7:0]  = nw[7:0];
        if (!be[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one command, check every cycle against the timeline, then the idle cycle after.
    task automatic drive_cmd(input string tag, input bit wr, input int addr, input int len,
                             input logic [1:0] be, input bit holdReq);
        int total;
        int k;
        int off;
        int a;
        logic [8:0] obsV;
        logic [8:0] expV;
        logic [15:0] expD;
        total = P * (len + 1);
        @(negedge iCLK);
        totalCnt++;
        if (bus.oREADY !== 1'b1) $display("FAIL %s ready_before got %b want 1", tag, bus.oREADY);
        else passCnt++;
        bus.iREQ   = 1'b1;
        bus.iWR    = wr;
        bus.iADDR  = AW'(addr);
        bus.iLEN   = 8'(len);
        bus.iBE_N  = be;
        bus.iWDATA = wr ? wq[0] : 16'($urandom);
        for (int c = 1; c <= total; c++) begin
            @(negedge iCLK);
            k   = (c - 1) / P;
            off = (c - 1) % P;
            a   = (addr + k) & AMASK;
            expV = {1'b0, 1'b0,
                    !(wr && off >= 1 && off <= AC),
                    !(!wr && off <= AC),
                    be,
                    (!wr && off == P - 1),
                    (k == len && off == P - 1),
                    (wr && k < len && off == P - 1)};
            obsV = {bus.oREADY, bus.oSRAM_CE_N, bus.oSRAM_WE_N, bus.oSRAM_OE_N, bus.oSRAM_BE_N,
                    bus.oRVALID, bus.oDONE, bus.oWNEXT};
            totalCnt++;
            if (obsV !== expV) $display("FAIL %s strobes cyc%0d got %b want %b", tag, c, obsV, expV);
            else passCnt++;
            totalCnt++;
            if (bus.oSRAM_ADDR !== AW'(a)) $display("FAIL %s addr cyc%0d got %h want %h", tag, c, bus.oSRAM_ADDR, a);
            else passCnt++;
            if (!wr && off == P - 1) begin
                expD = modelRd(a);
                totalCnt++;
                if (bus.oRDATA !== expD) $display("FAIL %s rdata word%0d got %h want %h", tag, k, bus.oRDATA, expD);
                else passCnt++;
            end
            if (c == 1) begin
                bus.iREQ  = holdReq;
                bus.iWR   = ~wr;
                bus.iADDR = AW'($urandom);
                bus.iLEN  = 8'($urandom);
                bus.iBE_N = ~be;
            end
            if (wr && off == P - 1 && k < len) bus.iWDATA = wq[k + 1];
            else bus.iWDATA = 16'($urandom);
        end
        @(negedge iCLK);
        obsV = {bus.oREADY, bus.oSRAM_CE_N, bus.oSRAM_WE_N, bus.oSRAM_OE_N, bus.oSRAM_BE_N,
                bus.oRVALID, bus.oDONE, bus.oWNEXT};
        totalCnt++;
        if (obsV !== 9'b1_1_1_1_11_000) $display("FAIL %s idle_after got %b want 111111000", tag, obsV);
        else passCnt++;
        bus.iREQ = 1'b0;
        if (wr) begin
            for (int j = 0; j <= len; j++) begin
                a = (addr + j) & AMASK;
                modelMem[a] = mergeBe(modelRd(a), wq[j], be);
                totalCnt++;
                if (sramMem[a] !== modelMem[a]) $display("FAIL %s mem[%h] got %h want %h", tag, a, sramMem[a], modelMem[a]);
                else passCnt++;
            end
        end
    endtask

    task automatic test_reset();
        logic [8:0] obsV;
        bus.iREQ = 1'b0; bus.iWR = 1'b0; bus.iADDR = '0; bus.iLEN = '0;
        bus.iBE_N = 2'b11; bus.iWDATA = '0;
        iRST_N = 1'b0;
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge iCLK);
            obsV = {bus.oREADY, bus.oSRAM_CE_N, bus.oSRAM_WE_N, bus.oSRAM_OE_N, bus.oSRAM_BE_N,
                    bus.oRVALID, bus.oDONE, bus.oWNEXT};
            totalCnt++;
            if (obsV !== 9'b1_1_1_1_11_000) $display("FAIL reset_idle cyc%0d got %b want 111111000", i, obsV);
            else passCnt++;
        end
        totalCnt++;
        if ({bus.oRDATA, bus.oSRAM_DATA, bus.oSRAM_ADDR} !== '0)
            $display("FAIL reset_data got %h/%h/%h want 0", bus.oRDATA, bus.oSRAM_DATA, bus.oSRAM_ADDR);
        else passCnt++;
    endtask

    task automatic test_single_write();
        wq = '{16'hA5C3};
        drive_cmd("single_write", 1'b1, 'h10, 0, 2'b00, 1'b0);
    endtask

    task automatic test_single_read();
        drive_cmd("single_read", 1'b0, 'h10, 0, 2'b00, 1'b0);
    endtask

    task automatic test_write_burst_wrap();
        wq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        drive_cmd("burst_write_wrap", 1'b1, 'h3FFFE, 3, 2'b00, 1'b0);
        totalCnt++;
        if (sramMem[0] !== 16'h0003 || sramMem[1] !== 16'h0004)
            $display("FAIL wrap_words got %h %h want 0003 0004", sramMem[0], sramMem[1]);
        else passCnt++;
    endtask

    task automatic test_read_burst_held_req();
        drive_cmd("burst_read_held", 1'b0, 'h3FFFE, 3, 2'b00, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [8:0] obsV;
        @(negedge iCLK);
        bus.iREQ = 1'b1; bus.iWR = 1'b1; bus.iADDR = 18'h2AAAA; bus.iLEN = 8'd2;
        bus.iBE_N = 2'b00; bus.iWDATA = 16'h1234;
        @(negedge iCLK);
        bus.iREQ = 1'b0;
        @(negedge iCLK);
        totalCnt++;
        if (bus.oSRAM_WE_N !== 1'b0) $display("FAIL rst_mid in_access got WE_N=%b want 0", bus.oSRAM_WE_N);
        else passCnt++;
        iRST_N = 1'b0;
        #1;
        obsV = {bus.oREADY, bus.oSRAM_CE_N, bus.oSRAM_WE_N, bus.oSRAM_OE_N, bus.oSRAM_BE_N,
                bus.oRVALID, bus.oDONE, bus.oWNEXT};
        totalCnt++;
        if (obsV !== 9'b1_1_1_1_11_000) $display("FAIL rst_mid async got %b want 111111000", obsV);
        else passCnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            totalCnt++;
            if (bus.oDONE !== 1'b0 || bus.oRVALID !== 1'b0)
                $display("FAIL rst_mid pulses cyc%0d got done=%b rvalid=%b want 0", i, bus.oDONE, bus.oRVALID);
            else passCnt++;
        end
        iRST_N = 1'b1;
        wq = '{16'h5A5A, 16'hC0DE};
        drive_cmd("post_rst_write", 1'b1, 'h2AAAA, 1, 2'b00, 1'b0);
        drive_cmd("post_rst_read", 1'b0, 'h2AAAA, 1, 2'b00, 1'b0);
    endtask

    task automatic test_random();
        int addr;
        int len;
        logic [1:0] be;
        for (int i = 0; i < 8; i++) begin
            addr = ($urandom_range(0, 3) == 0) ? ('h3FFFC + $urandom_range(0, 3)) : ($urandom & AMASK);
            len  = $urandom_range(0, 4);
            be   = 2'($urandom_range(0, 3));
            wq.delete();
            for (int j = 0; j <= len; j++) wq.push_back(16'($urandom));
            drive_cmd("rand_write", 1'b1, addr, len, be, 1'b0);
            drive_cmd("rand_read", 1'b0, addr, len, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_write_burst_wrap();
        test_read_burst_held_req();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
